// File: rtl/div_mon_pkg.sv
// Shared types and defaults for the divided-clock period monitor.
// Holds the monitor FSM state encoding and the default counter width.
package div_mon_pkg;

    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        HIGH,
        LOW
    } mon_state_e;

endpackage

// File: rtl/edge_det.sv
// Rise/fall detector for a signal already synchronous to clk.
// One sample register; edges are combinational against the sample.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic d1_q;
    logic d1_d;

    // Next sample is simply the current input.
    always_comb begin
        d1_d = din;
    end

    // Sample register, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) d1_q <= 1'b0;
        else     d1_q <= d1_d;
    end

    assign rise = din & ~d1_q;
    assign fall = ~din & d1_q;

endmodule

// File: rtl/div_period_monitor.sv
// Measures high/low/period of a divided clock in clk cycles, checks lock.
// Build option DIV_MON_TOL_EN: accept +/-1 cycle on each phase.
module div_period_monitor
    import div_mon_pkg::*;
#(
    parameter int          CNT_W      = DEF_CNT_W,
    parameter int unsigned EXP_HIGH   = 2,
    parameter int unsigned EXP_LOW    = 3,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clk_div_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_mismatch,
    output logic             err_ovf
);

    localparam logic [CNT_W-1:0] EXP_H  = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] EXP_L  = CNT_W'(EXP_LOW);
    localparam logic [3:0]       LOCK_C = 4'(LOCK_COUNT);

    logic rise;
    logic fall;

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   period_q, period_d;
    logic             mv_q, mv_d;
    logic             lock_q, lock_d;
    logic             emm_q, emm_d;
    logic             eovf_q, eovf_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [3:0]       mcnt_inc;
    logic             set_mm;
    logic             set_ovf;
    logic             match;

    edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (clk_div_in),
        .rise (rise),
        .fall (fall)
    );

`ifdef DIV_MON_TOL_EN
    function automatic logic near(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] e
    );
        logic [CNT_W-1:0] diff;
        diff = (a >= e) ? (a - e) : (e - a);
        return diff <= CNT_W'(1);
    endfunction

    assign match = near(hcnt_q, EXP_H) && near(lcnt_q, EXP_L);
`else
    assign match = (hcnt_q == EXP_H) && (lcnt_q == EXP_L);
`endif

    assign mcnt_inc = (mcnt_q == LOCK_C) ? mcnt_q : mcnt_q + 4'd1;

    // Phase tracking, publish, lock and sticky-error next-state logic.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        high_d   = high_q;
        low_d    = low_q;
        period_d = period_q;
        mv_d     = 1'b0;
        lock_d   = lock_q;
        mcnt_d   = mcnt_q;
        set_mm   = 1'b0;
        set_ovf  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            lock_d  = 1'b0;
            mcnt_d  = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_RISE;
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = HIGH;
                        hcnt_d  = CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        lcnt_d  = CNT_W'(1);
                    end else if (&hcnt_q) begin
                        set_ovf = 1'b1;
                        lock_d  = 1'b0;
                        mcnt_d  = 4'd0;
                        state_d = WAIT_RISE;
                    end else begin
                        hcnt_d = hcnt_q + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        high_d   = hcnt_q;
                        low_d    = lcnt_q;
                        period_d = {1'b0, hcnt_q} + {1'b0, lcnt_q};
                        mv_d     = 1'b1;
                        state_d  = HIGH;
                        hcnt_d   = CNT_W'(1);
                        if (match) begin
                            mcnt_d = mcnt_inc;
                            lock_d = (mcnt_inc == LOCK_C);
                        end else begin
                            mcnt_d = 4'd0;
                            lock_d = 1'b0;
                            set_mm = 1'b1;
                        end
                    end else if (&lcnt_q) begin
                        set_ovf = 1'b1;
                        lock_d  = 1'b0;
                        mcnt_d  = 4'd0;
                        state_d = WAIT_RISE;
                    end else begin
                        lcnt_d = lcnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        emm_d  = (emm_q & ~err_clr) | set_mm;
        eovf_d = (eovf_q & ~err_clr) | set_ovf;
    end

    // State and output registers, synchronous reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            high_q   <= '0;
            low_q    <= '0;
            period_q <= '0;
            mv_q     <= 1'b0;
            lock_q   <= 1'b0;
            emm_q    <= 1'b0;
            eovf_q   <= 1'b0;
            mcnt_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            high_q   <= high_d;
            low_q    <= low_d;
            period_q <= period_d;
            mv_q     <= mv_d;
            lock_q   <= lock_d;
            emm_q    <= emm_d;
            eovf_q   <= eovf_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign high_cnt     = high_q;
    assign low_cnt      = low_q;
    assign period_cnt   = period_q;
    assign meas_valid   = mv_q;
    assign locked       = lock_q;
    assign err_mismatch = emm_q;
    assign err_ovf      = eovf_q;

endmodule

// File: tb/tb_div_period_monitor.sv
// Randomized bench for div_period_monitor against a run-length model.
// Directed scenarios first, then random periods, enables, clears, resets.
module tb_div_period_monitor;

    localparam int EH  = 2;
    localparam int EL  = 3;
    localparam int LC  = 4;
    localparam int MAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clk_div_in = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] high_cnt;
    logic [7:0] low_cnt;
    logic [8:0] period_cnt;
    logic       meas_valid;
    logic       locked;
    logic       err_mismatch;
    logic       err_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state, in terms of runs of the input level
    bit prev;
    bit active;
    bit armed;
    bit in_high;
    int run;
    int hlen;
    int mcount;
    int m_high, m_low, m_period;
    bit m_mv, m_lock, m_mm, m_ovf;

    div_period_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clk_div_in   (clk_div_in),
        .err_clr      (err_clr),
        .high_cnt     (high_cnt),
        .low_cnt      (low_cnt),
        .period_cnt   (period_cnt),
        .meas_valid   (meas_valid),
        .locked       (locked),
        .err_mismatch (err_mismatch),
        .err_ovf      (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int obs, int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      tag, obs, exp, $time);
    endtask

    function automatic bit ok_len(int a, int e);
`ifdef DIV_MON_TOL_EN
        return ((a > e) ? a - e : e - a) <= 1;
`else
        return a == e;
`endif
    endfunction

    // Advance the model by one clk edge using the applied inputs.
    task automatic model_step();
        bit rise, fall, s_mm, s_ovf;
        if (rst) begin
            prev = 0; active = 0; armed = 0; in_high = 0;
            run = 0; hlen = 0; mcount = 0;
            m_high = 0; m_low = 0; m_period = 0;
            m_mv = 0; m_lock = 0; m_mm = 0; m_ovf = 0;
            return;
        end
        rise = clk_div_in && !prev;
        fall = !clk_div_in && prev;
        prev = clk_div_in;
        s_mm = 0;
        s_ovf = 0;
        m_mv = 0;
        if (!enable) begin
            active = 0;
            armed = 0;
            m_lock = 0;
            mcount = 0;
        end else if (!active) begin
            active = 1;
        end else if (!armed) begin
            if (rise) begin
                armed = 1; in_high = 1; run = 1;
            end
        end else if (in_high) begin
            if (fall) begin
                hlen = run; run = 1; in_high = 0;
            end else if (run == MAX) begin
                s_ovf = 1; armed = 0; m_lock = 0; mcount = 0;
            end else run++;
        end else begin
            if (rise) begin
                m_high = hlen;
                m_low = run;
                m_period = hlen + run;
                m_mv = 1;
                if (ok_len(hlen, EH) && ok_len(run, EL)) begin
                    mcount = (mcount + 1 > LC) ? LC : mcount + 1;
                    m_lock = (mcount == LC);
                end else begin
                    mcount = 0; m_lock = 0; s_mm = 1;
                end
                in_high = 1; run = 1;
            end else if (run == MAX) begin
                s_ovf = 1; armed = 0; m_lock = 0; mcount = 0;
            end else run++;
        end
        m_mm  = (m_mm && !err_clr) || s_mm;
        m_ovf = (m_ovf && !err_clr) || s_ovf;
    endtask

    task automatic cyc(bit din, bit en = 1, bit clr = 0, bit r = 0);
        @(negedge clk);
        clk_div_in = din;
        enable = en;
        err_clr = clr;
        rst = r;
        @(posedge clk);
        model_step();
        #1;
        check("high_cnt", int'(high_cnt), m_high);
        check("low_cnt", int'(low_cnt), m_low);
        check("period_cnt", int'(period_cnt), m_period);
        check("meas_valid", int'(meas_valid), int'(m_mv));
        check("locked", int'(locked), int'(m_lock));
        check("err_mismatch", int'(err_mismatch), int'(m_mm));
        check("err_ovf", int'(err_ovf), int'(m_ovf));
    endtask

    task automatic period(int h, int l);
        for (int i = 0; i < h; i++) cyc(1);
        for (int i = 0; i < l; i++) cyc(0);
    endtask

    initial begin
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("rst_period", int'(period_cnt), 0);
        check("rst_locked", int'(locked), 0);

        // steady 2/3: lock on the 4th published period
        cyc(0);
        for (int i = 0; i < 6; i++) period(EH, EL);
        cyc(1);
        check("steady_high", int'(high_cnt), 2);
        check("steady_low", int'(low_cnt), 3);
        check("steady_period", int'(period_cnt), 5);
        check("steady_locked", int'(locked), 1);
        check("steady_mv", int'(meas_valid), 1);
        cyc(1);
        for (int i = 0; i < EL; i++) cyc(0);

        // one 3/3 period, with err_clr landing on the publish
        period(3, 3);
        cyc(1, 1, 1);
        check("inj_period", int'(period_cnt), 6);
        check("inj_mm_set_wins", int'(err_mismatch), 1);
        check("inj_unlock", int'(locked), 0);
        cyc(1, 1, 1);
        check("clr_alone", int'(err_mismatch), 0);
        for (int i = 0; i < EL; i++) cyc(0);
        for (int i = 0; i < 5; i++) period(EH, EL);

        // stuck high overflows the high counter
        for (int i = 0; i < 300; i++) cyc(1);
        check("ovf_set", int'(err_ovf), 1);
        check("ovf_period_hold", int'(period_cnt), 5);
        for (int i = 0; i < 3; i++) cyc(0);
        for (int i = 0; i < 6; i++) period(EH, EL);

        // enable dropped mid-high, then re-enabled
        cyc(1);
        cyc(1, 0);
        check("dis_unlock", int'(locked), 0);
        check("dis_hold", int'(period_cnt), 5);
        for (int i = 0; i < 3; i++) cyc(0, 0);
        for (int i = 0; i < 6; i++) period(EH, EL);

        // reset mid-low while locked
        cyc(1); cyc(1); cyc(0);
        cyc(0, 1, 0, 1);
        check("rstlow_locked", int'(locked), 0);
        check("rstlow_high", int'(high_cnt), 0);
        cyc(0);

        // random periods mostly near nominal, with disturbances
        for (int n = 0; n < 400; n++) begin
            int h, l, sel;
            sel = $urandom_range(0, 99);
            h = (sel < 70) ? EH : $urandom_range(1, 5);
            l = (sel < 70) ? EL : $urandom_range(1, 5);
            if (sel == 99) h = $urandom_range(256, 262);
            for (int i = 0; i < h + l; i++) begin
                bit en, clr, r;
                en = ($urandom_range(0, 99) >= 2);
                clr = ($urandom_range(0, 99) < 4);
                r = ($urandom_range(0, 999) < 3);
                cyc(i < h, en, clr, r);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/div_period_monitor.md
Name: div_period_monitor

Overview:
- Downstream consumer of the odd-ratio clock divider output; samples the divided clock as data in the source clock domain.
- Measures the high-phase, low-phase and full-period length of every divided-clock cycle in source-clock cycles.
- Compares each measurement against expected values, reports lock, and raises sticky error flags for mismatch or stuck/overflowing input.
- Used as a self-check alongside the divider and by bring-up status registers.

Parameters:
- CNT_W, 8, width of the phase counters and measurement outputs.
- EXP_HIGH, 2, expected high-phase length in clk cycles.
- EXP_LOW, 3, expected low-phase length in clk cycles.
- LOCK_COUNT, 4, consecutive matching periods required before locked asserts; range 1..15.

Ports:
- clk  input  1  source clock; also the divider's input clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  monitor enable.
- clk_div_in  input  1  divided clock, synchronous to clk.
- err_clr  input  1  one-cycle pulse that clears the sticky error flags.
- high_cnt  output  CNT_W  last measured high-phase length.
- low_cnt  output  CNT_W  last measured low-phase length.
- period_cnt  output  CNT_W+1  last measured high_cnt+low_cnt.
- meas_valid  output  1  one-cycle pulse when the measurement outputs update.
- locked  output  1  set after LOCK_COUNT consecutive matching periods.
- err_mismatch  output  1  sticky flag: a measured period did not match.
- err_ovf  output  1  sticky flag: a phase counter saturated.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it wins over all other inputs.
- Reset values: every output 0, state IDLE, edge register d1=0, match counter 0.
- Edge detection:
  - d1 samples clk_div_in every cycle, regardless of state.
  - rise = clk_div_in & ~d1; fall = ~clk_div_in & d1 (combinational).
- FSM states:
  - IDLE: on enable=1, go to WAIT_RISE.
  - WAIT_RISE: discards the partial period. On rise, go to HIGH with hcnt<=1.
  - HIGH: on fall, go to LOW with lcnt<=1; otherwise hcnt<=hcnt+1.
  - LOW: on rise, publish the measurement, then go to HIGH with hcnt<=1; otherwise lcnt<=lcnt+1.
- Publish:
  - high_cnt<=hcnt, low_cnt<=lcnt, period_cnt<=hcnt+lcnt (zero-extended, no overflow possible).
  - meas_valid=1 for exactly that one cycle, registered: visible the cycle after the clk edge that samples the rise.
- Example: input high 2 cycles, low 3 cycles gives high_cnt=2, low_cnt=3, period_cnt=5, with meas_valid pulsing every 5 cycles.
- Match evaluation (at publish only):
  - match = (hcnt==EXP_HIGH)&&(lcnt==EXP_LOW).
  - On match: match_cnt increments, saturating at LOCK_COUNT; locked<=1 when the new value equals LOCK_COUNT.
  - On mismatch: match_cnt<=0, locked<=0, err_mismatch<=1.
- Overflow: if hcnt or lcnt is all-ones and the phase does not end that cycle:
  - err_ovf<=1, locked<=0, match_cnt<=0, go to WAIT_RISE.
  - No publish occurs.
- enable=0 in any state:
  - Next state is IDLE; an in-flight measurement is discarded with no meas_valid.
  - locked<=0, match_cnt<=0.
  - Measurement outputs and sticky flags hold.
- err_clr clears both sticky flags. If an error is set in the same cycle, set wins and the flag stays 1.
- Rise and fall cannot coincide (single-bit input), so no simultaneous-edge case exists.

Optional Feature:
- Macro: DIV_MON_TOL_EN.
- Defined: match uses ±1 tolerance, |hcnt-EXP_HIGH|<=1 && |lcnt-EXP_LOW|<=1, evaluated without signed wrap.
- Undefined: exact equality as above. No port changes in either case.

Decomposition:
- Package div_mon_pkg: FSM state enum (IDLE, WAIT_RISE, HIGH, LOW) and default CNT_W constant.
- Sub-module edge_det:
  - Contains the d1 register plus rise/fall outputs.
  - Synchronous active-high reset.
  - Reusable by other clock-consuming stages.

Test Plan:
- Steady 2-high/3-low input, LOCK_COUNT=4, enable=1: meas_valid every 5 cycles, high_cnt=2, low_cnt=3, period_cnt=5; locked=1 from the 4th meas_valid onward; no errors.
- After lock, inject one 3-high/3-low period: that meas_valid shows period_cnt=6; err_mismatch=1 and locked=0 the same cycle; locked returns 4 good periods later.
- CNT_W=8, hold clk_div_in high for 300 cycles: err_ovf=1 once hcnt=255; no meas_valid; FSM waits for the next rise.
- Deassert enable mid-HIGH: no meas_valid; locked=0 next cycle; outputs hold previous values; re-enable discards the first partial period.
- err_clr pulsed in the same cycle a mismatch is published: err_mismatch stays 1. err_clr alone a cycle later: err_mismatch=0.
- Assert rst mid-LOW with locked=1: the next cycle shows all outputs 0 and state IDLE.
